// File: rtl/esaxi_wbuf.sv
// Write-beat buffer: captures accepted AXI W beats in a FIFO and drains them to the backend write port.
// Optional ESAXI_WBUF_STATS_EN adds beat and burst counters.
module esaxi_wbuf #(
    parameter int DEPTH = 8,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            beat_valid,
    input  logic [AW-1:0]   beat_addr,
    input  logic [DW-1:0]   beat_data,
    input  logic [DW/8-1:0] beat_strb,
    input  logic            beat_last,
    output logic            write_ready,
    output logic            mem_req,
    input  logic            mem_ack,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_data,
    output logic [DW/8-1:0] mem_strb,
    output logic            mem_last,
    output logic            ovf_err
`ifdef ESAXI_WBUF_STATS_EN
    ,
    output logic [31:0]     stat_beats,
    output logic [15:0]     stat_bursts
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DW / 8;
    localparam int EW = AW + DW + SW + 1;

    typedef enum logic {OUT_EMPTY, OUT_VALID} out_state_e;

    logic [EW-1:0] store [DEPTH];
    logic [EW-1:0] head;
    logic [PW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    out_state_e    state, state_nx;
    logic          push, pop, fifo_empty;

    assign fifo_empty  = (count == '0);
    assign push        = beat_valid && (count != CW'(DEPTH));
    // Two free slots: the slave sees ready one cycle late, so one beat may still land.
    assign write_ready = (count <= CW'(DEPTH - 2));
    assign head        = store[rptr];

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        mem_req  = 1'b0;
        case (state)
            OUT_EMPTY: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = OUT_VALID;
                end
            end
            OUT_VALID: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nx = OUT_EMPTY;
                end
            end
            default: state_nx = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) store[wptr] <= {beat_addr, beat_data, beat_strb, beat_last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OUT_EMPTY;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            ovf_err  <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_strb <= '0;
            mem_last <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (beat_valid && !push) ovf_err <= 1'b1;
            if (pop) {mem_addr, mem_data, mem_strb, mem_last} <= head;
        end
    end

`ifdef ESAXI_WBUF_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats  <= '0;
            stat_bursts <= '0;
        end else begin
            if (push) stat_beats <= stat_beats + 1'b1;
            if (mem_req && mem_ack && mem_last) stat_bursts <= stat_bursts + 1'b1;
        end
    end
`endif

endmodule
